// File: rtl/adc_capture_seq.sv
// ADC frame capture sequencer: writes a burst of ADC samples into an external
// synchronous RAM, then streams them back out with a valid/ready handshake.
module adc_capture_seq #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        PRESENT = 3'd4,
        FIN     = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] wcnt;
    logic [ADDR_W:0] rcnt;
    logic [ADDR_W:0] last_idx;
    logic            wr_hit;
    logic            wr_last;
    logic            rd_acc;
    logic            rd_last;

    // Abort outranks sample writes and word acceptance in the same cycle.
    assign last_idx = len - ONE;
    assign wr_hit   = (state == CAPTURE) && adc_valid && !abort;
    assign wr_last  = wr_hit && (wcnt == last_idx);
    assign rd_acc   = (state == PRESENT) && out_ready && !abort;
    assign rd_last  = (rcnt == last_idx);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = CAPTURE;
                CAPTURE: if (wr_last) state_nxt = RD_ADDR;
                RD_ADDR: state_nxt = RD_WAIT;
                RD_WAIT: state_nxt = PRESENT;
                PRESENT: if (rd_acc) state_nxt = rd_last ? FIN : RD_ADDR;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counters are one bit wider than the address so a full-depth frame ends cleanly.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            len      <= FULL_LEN;
            wcnt     <= '0;
            rcnt     <= '0;
            out_data <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                len  <= (cfg_len == '0) ? FULL_LEN : cfg_len;
                wcnt <= '0;
            end
            if (wr_hit) begin
                wcnt <= wcnt + ONE;
            end
            if (wr_last) begin
                rcnt <= '0;
            end
            if (state == RD_WAIT) begin
                out_data <= ram_rdata;
            end
            if (rd_acc) begin
                rcnt <= rcnt + ONE;
            end
        end
    end

    always_comb begin
        ram_we    = wr_hit;
        ram_waddr = wcnt[ADDR_W-1:0];
        ram_wdata = wr_hit ? adc_data : '0;
        ram_raddr = rcnt[ADDR_W-1:0];
        out_valid = (state == PRESENT);
        out_last  = (state == PRESENT) && rd_last;
        busy      = (state != IDLE);
        done      = (state == FIN);
    end

endmodule
